alu_daa: RTL and testbench

ALU_DAA -- requirements
Module: alu_daa

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_daa_if.sv | 30 +++
 rtl/alu_daa_decimal_adjust.sv | 36 +++
 rtl/alu_daa.sv | 150 +++++++++++++++
 tb/tb_alu_daa.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// alu_pkg -- shared definitions for the alu_daa block.
// Holds the operation-select encodings, the sequencing FSM state encoding and
// the BCD nibble limit used by the decimal correction.
package alu_pkg;

  localparam logic [2:0] OP_SUM = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_EOR = 3'd4;
  localparam logic [2:0] OP_SR  = 3'd5;

  // Largest legal BCD digit.
  localparam logic [3:0] NIBBLE_LIMIT = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_SUM) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_daa_if.sv
// alu_daa_if -- operation request / result bus of the alu_daa block.
//   master: drives op_start, op_sel, a_in, b_in, carry_in, dec_en;
//           observes add_out, busy, daa_data, daa_valid, c/v/n/z_out.
//   slave : the ALU side (opposite directions).
interface alu_daa_if;
  logic       op_start;
  logic [2:0] op_sel;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic       carry_in;
  logic       dec_en;
  logic [7:0] add_out;
  logic       busy;
  logic [7:0] daa_data;
  logic       daa_valid;
  logic       c_out;
  logic       v_out;
  logic       n_out;
  logic       z_out;

  modport master (
    output op_start, op_sel, a_in, b_in, carry_in, dec_en,
    input  add_out, busy, daa_data, daa_valid, c_out, v_out, n_out, z_out
  );

  modport slave (
    input  op_start, op_sel, a_in, b_in, carry_in, dec_en,
    output add_out, busy, daa_data, daa_valid, c_out, v_out, n_out, z_out
  );
endinterface

// File: rtl/alu_daa_decimal_adjust.sv
// decimal_adjust -- combinational BCD correction of a binary add/subtract.
// Ports: result (binary byte), half_carry (carry out of bit 3), carry
// (carry out of bit 7), sub (1 = subtraction); adjusted (corrected byte),
// carry_out (decimal carry).
module decimal_adjust
  import alu_pkg::*;
(
  input  logic [7:0] result,
  input  logic       half_carry,
  input  logic       carry,
  input  logic       sub,
  output logic [7:0] adjusted,
  output logic       carry_out
);

  logic [8:0] lo_fixed;
  logic       hi_fix;

  always_comb begin
    adjusted  = result;
    carry_out = carry;
    lo_fixed  = {1'b0, result};
    hi_fix    = 1'b0;
    if (sub) begin
      adjusted = result - (half_carry ? 8'h00 : 8'h06) - (carry ? 8'h00 : 8'h60);
    end else begin
      if ((result[3:0] > NIBBLE_LIMIT) || half_carry)
        lo_fixed = {1'b0, result} + 9'h006;
      // Upper digit is judged after the low fix so a ripple from it counts.
      hi_fix    = (lo_fixed[8:4] > {1'b0, NIBBLE_LIMIT}) || carry;
      adjusted  = lo_fixed[7:0] + (hi_fix ? 8'h60 : 8'h00);
      carry_out = hi_fix;
    end
  end

endmodule

// File: rtl/alu_daa.sv
// alu_daa -- two-stage ALU with optional decimal adjust.
// Stage 1 (IDLE/OUT -> HOLD) captures the raw ALU result in add_out; stage 2
// (HOLD -> OUT) captures the adjusted result and flags, daa_valid marks OUT.
// Ports: clk, rst (synchronous, active high), bus (alu_daa_if.slave).
// Build option: ALU_DECIMAL_MODE_EN enables BCD correction; when undefined
// dec_en is ignored and daa_data always equals add_out.
module alu_daa
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  alu_daa_if.slave   bus
);

  state_e     state, state_nx;
  logic       capture, finish;

  logic [7:0] b_eff, raw;
  logic [8:0] sum9;
  logic       raw_c, raw_v;

  logic [7:0] add_q, daa_q, daa_next;
  logic       hold_c, hold_v, c_next;
  logic       c_q, v_q, n_q, z_q;

`ifdef ALU_DECIMAL_MODE_EN
  logic [4:0] lo5;
  logic       hold_hc, hold_dec, hold_sub;
  logic [7:0] adj_data;
  logic       adj_c;
`endif

  always_comb begin
    b_eff = (bus.op_sel == OP_SUB) ? ~bus.b_in : bus.b_in;
    sum9  = {1'b0, bus.a_in} + {1'b0, b_eff} + {8'd0, bus.carry_in};
    raw   = 8'h00;
    raw_c = 1'b0;
    raw_v = 1'b0;
    case (bus.op_sel)
      OP_SUM, OP_SUB: begin
        raw   = sum9[7:0];
        raw_c = sum9[8];
        raw_v = (bus.a_in[7] == b_eff[7]) && (sum9[7] != bus.a_in[7]);
      end
      OP_AND: raw = bus.a_in & bus.b_in;
      OP_OR:  raw = bus.a_in | bus.b_in;
      OP_EOR: raw = bus.a_in ^ bus.b_in;
      OP_SR: begin
        raw   = {bus.carry_in, bus.a_in[7:1]};
        raw_c = bus.a_in[0];
      end
      default: ;
    endcase
  end

`ifdef ALU_DECIMAL_MODE_EN
  assign lo5 = {1'b0, bus.a_in[3:0]} + {1'b0, b_eff[3:0]} + {4'd0, bus.carry_in};

  decimal_adjust u_decimal_adjust (
    .result     (add_q),
    .half_carry (hold_hc),
    .carry      (hold_c),
    .sub        (hold_sub),
    .adjusted   (adj_data),
    .carry_out  (adj_c)
  );

  assign daa_next = hold_dec ? adj_data : add_q;
  assign c_next   = hold_dec ? adj_c    : hold_c;
`else
  assign daa_next = add_q;
  assign c_next   = hold_c;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    capture  = 1'b0;
    finish   = 1'b0;
    case (state)
      ST_IDLE: if (bus.op_start) begin
        capture  = 1'b1;
        state_nx = ST_HOLD;
      end
      ST_HOLD: begin
        finish   = 1'b1;
        state_nx = ST_OUT;
      end
      ST_OUT: begin
        if (bus.op_start) begin
          capture  = 1'b1;
          state_nx = ST_HOLD;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      add_q  <= 8'h00;
      hold_c <= 1'b0;
      hold_v <= 1'b0;
      daa_q  <= 8'h00;
      c_q    <= 1'b0;
      v_q    <= 1'b0;
      n_q    <= 1'b0;
      z_q    <= 1'b0;
`ifdef ALU_DECIMAL_MODE_EN
      hold_hc  <= 1'b0;
      hold_dec <= 1'b0;
      hold_sub <= 1'b0;
`endif
    end else begin
      if (capture) begin
        add_q  <= raw;
        hold_c <= raw_c;
        hold_v <= raw_v;
`ifdef ALU_DECIMAL_MODE_EN
        hold_hc  <= lo5[4];
        hold_dec <= bus.dec_en && is_arith(bus.op_sel);
        hold_sub <= (bus.op_sel == OP_SUB);
`endif
      end
      if (finish) begin
        daa_q <= daa_next;
        c_q   <= c_next;
        v_q   <= hold_v;
        n_q   <= daa_next[7];
        z_q   <= (daa_next == 8'h00);
      end
    end
  end

  assign bus.add_out   = add_q;
  assign bus.busy      = (state == ST_HOLD);
  assign bus.daa_data  = daa_q;
  assign bus.daa_valid = (state == ST_OUT);
  assign bus.c_out     = c_q;
  assign bus.v_out     = v_q;
  assign bus.n_out     = n_q;
  assign bus.z_out     = z_q;

endmodule

// File: tb/tb_alu_daa.sv
// tb_alu_daa -- self-checking bench for alu_daa: directed corner cases plus
// randomized operations against an arithmetic reference model.
// Honours ALU_DECIMAL_MODE_EN the same way as the design.
module tb_alu_daa;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  alu_daa_if bus ();

  alu_daa dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int add;
    int dd;
    int c;
    int v;
    int n;
    int z;
  } res_t;

  res_t last;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic res_t ref_model(input int op, input int a, input int b,
                                     input int c, input int dec);
    res_t o;
    int bb, s, r, t, bc, hc, vv, cc;
    bb = b; bc = 0; hc = 0; vv = 0; r = 0;
    case (op)
      0, 1: begin
        if (op == 1) bb = (~b) & 255;
        s  = a + bb + c;
        r  = s & 255;
        bc = s >> 8;
        hc = (((a & 15) + (bb & 15) + c) > 15) ? 1 : 0;
        vv = (((a >> 7) == (bb >> 7)) && (((r >> 7) & 1) != (a >> 7))) ? 1 : 0;
      end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: begin
        r  = (c << 7) | (a >> 1);
        bc = a & 1;
      end
      default: r = 0;
    endcase
    t  = r;
    cc = bc;
`ifdef ALU_DECIMAL_MODE_EN
    if (dec != 0 && op == 0) begin
      if ((t & 15) > 9 || hc != 0) t = t + 6;
      if ((t >> 4) > 9 || bc != 0) begin
        t  = t + 96;
        cc = 1;
      end
      t = t & 255;
    end
    if (dec != 0 && op == 1) begin
      if (hc == 0) t = t - 6;
      if (bc == 0) t = t - 96;
      t = t & 255;
    end
`endif
    o.add = r;
    o.dd  = t;
    o.c   = cc;
    o.v   = vv;
    o.n   = (t >> 7) & 1;
    o.z   = (t == 0) ? 1 : 0;
    return o;
  endfunction

  // Called at a negedge; leaves the DUT in OUT at a negedge.
  task automatic do_op(input int op, input int a, input int b, input int c,
                       input int dec, input int hold_start);
    res_t e;
    e = ref_model(op, a, b, c, dec);
    bus.op_start = 1'b1;
    bus.op_sel   = 3'(op);
    bus.a_in     = 8'(a);
    bus.b_in     = 8'(b);
    bus.carry_in = 1'(c);
    bus.dec_en   = 1'(dec);
    @(negedge clk);
    chk("add_out", bus.add_out, e.add);
    chk("busy_hold", bus.busy, 1);
    chk("valid_hold", bus.daa_valid, 0);
    // A start during HOLD, with unrelated operands, must be ignored.
    bus.op_start = 1'(hold_start);
    bus.op_sel   = 3'($urandom_range(0, 7));
    bus.a_in     = 8'($urandom);
    bus.b_in     = 8'($urandom);
    bus.carry_in = 1'($urandom_range(0, 1));
    bus.dec_en   = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk("daa_data", bus.daa_data, e.dd);
    chk("c_out", bus.c_out, e.c);
    chk("v_out", bus.v_out, e.v);
    chk("n_out", bus.n_out, e.n);
    chk("z_out", bus.z_out, e.z);
    chk("valid_out", bus.daa_valid, 1);
    chk("busy_out", bus.busy, 0);
    chk("add_out_held", bus.add_out, e.add);
    bus.op_start = 1'b0;
    last = e;
  endtask

  task automatic idle_cycle();
    bus.op_start = 1'b0;
    @(negedge clk);
    chk("valid_idle", bus.daa_valid, 0);
    chk("busy_idle", bus.busy, 0);
    chk("daa_held", bus.daa_data, last.dd);
  endtask

  task automatic check_zeroed(input string tag);
    chk({tag, "_add"}, bus.add_out, 0);
    chk({tag, "_daa"}, bus.daa_data, 0);
    chk({tag, "_flags"}, {bus.c_out, bus.v_out, bus.n_out, bus.z_out}, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_valid"}, bus.daa_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst          = 1'b1;
    bus.op_start = 1'b1;
    bus.op_sel   = 3'd0;
    bus.a_in     = 8'h55;
    bus.b_in     = 8'h33;
    bus.carry_in = 1'b0;
    bus.dec_en   = 1'b0;
    repeat (2) @(negedge clk);
    check_zeroed("reset");
    rst          = 1'b0;
    bus.op_start = 1'b0;
    last         = ref_model(7, 0, 0, 0, 0);
    idle_cycle();

    // Directed corner cases.
    do_op(0, 8'h50, 8'h50, 0, 0, 0);
    idle_cycle();
    do_op(0, 8'h19, 8'h28, 0, 1, 0);
    do_op(0, 8'h99, 8'h01, 0, 1, 1);
    do_op(1, 8'h10, 8'h01, 1, 1, 0);
    idle_cycle();
    do_op(5, 8'h81, 8'h00, 1, 1, 1);
    do_op(5, 8'h81, 8'h00, 1, 0, 1);
    do_op(6, 8'hFF, 8'hFF, 1, 0, 1);
    do_op(7, 8'h12, 8'h34, 1, 1, 0);
    do_op(2, 8'hF0, 8'h0F, 1, 0, 0);
    idle_cycle();

    // Reset in HOLD aborts with no valid pulse; reset beats op_start.
    bus.op_start = 1'b1;
    bus.op_sel   = 3'd0;
    bus.a_in     = 8'h7F;
    bus.b_in     = 8'h01;
    bus.carry_in = 1'b0;
    @(negedge clk);
    chk("busy_pre_rst", bus.busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check_zeroed("rst_hold");
    rst          = 1'b0;
    bus.op_start = 1'b0;
    last         = ref_model(7, 0, 0, 0, 0);
    idle_cycle();
    do_op(0, 8'h7F, 8'h01, 0, 0, 0);

    // Reset in OUT.
    rst = 1'b1;
    @(negedge clk);
    check_zeroed("rst_out");
    rst  = 1'b0;
    last = ref_model(7, 0, 0, 0, 0);
    idle_cycle();

    // Randomized operations, mixing back-to-back and gapped issue.
    for (int i = 0; i < 300; i++) begin
      do_op($urandom_range(0, 7), $urandom_range(0, 255), $urandom_range(0, 255),
            $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) idle_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
